// File: rtl/uart_tx_word_pkg.sv
// uart_tx_word_pkg
// Shared definitions for the word-to-UART drain stage: FSM state encoding,
// 8N1 frame geometry and the default baud divisor (100 MHz / 115200).
package uart_tx_word_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_LATCH = 3'd2,
    ST_START = 3'd3,
    ST_DATA  = 3'd4,
    ST_STOP  = 3'd5
  } state_e;

  localparam int DATA_BITS            = 8;   // payload bits per frame
  localparam int FRAME_BITS           = 10;  // start + 8 data + stop
  localparam int DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_tx_word_baud_tick.sv
// uart_baud_tick
// Free-running bit-period counter. Counts 0..CLKS_PER_BIT-1 and flags the
// last cycle of every bit period. A synchronous clear holds the count at
// zero, so the first period after clear is released is a full one.
//
// Ports:
//   clk      in   system clock
//   reset    in   synchronous, active-high
//   clear_i  in   hold counter at 0 (and suppress tick) while high
//   tick_o   out  high on the last cycle of each CLKS_PER_BIT-cycle period
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear_i || (cnt_q == LAST_CNT)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = ~clear_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/uart_tx_word.sv
// uart_tx_word
// Drain stage behind the word FIFO. Pops one WIDTH-bit word per request and
// sends it as WIDTH/8 back-to-back 8N1 UART frames, byte 0 (word[7:0])
// first, LSB first within each byte. A popped word equal to EMPTY_WORD is
// the FIFO's "read while empty" value and is dropped with an empty_seen
// pulse instead of being transmitted. WIDTH must be a multiple of 8 and
// CLKS_PER_BIT must be at least 2.
//
// Ports:
//   clk         in   system clock, all logic on posedge
//   reset       in   synchronous, active-high
//   enable      in   level; keep pulling words while high
//   fifo_read   out  one-cycle read strobe to the FIFO
//   fifo_data   in   FIFO data_out, valid the cycle after fifo_read
//   tx          out  UART serial line, idle high
//   busy        out  high whenever the FSM is outside IDLE
//   word_done   out  one-cycle pulse after the last stop bit of a word
//   empty_seen  out  one-cycle pulse when the popped word is EMPTY_WORD
module uart_tx_word
  import uart_tx_word_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter int               CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter logic [WIDTH-1:0] EMPTY_WORD   = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic             fifo_read,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             tx,
  output logic             busy,
  output logic             word_done,
  output logic             empty_seen
);

  localparam int NUM_BYTES = WIDTH / DATA_BITS;
  localparam int BYTE_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NUM_BYTES - 1);
  localparam logic [2:0]        LAST_BIT  = 3'(DATA_BITS - 1);

  state_e           state_q;
  logic [WIDTH-1:0] word_q;
  logic [7:0]       shift_q;
  logic [2:0]       bit_idx_q;
  logic [BYTE_W-1:0] byte_idx_q;
  logic             tx_q;
  logic             fifo_read_q;
  logic             busy_q;
  logic             word_done_q;
  logic             empty_seen_q;

  logic              baud_clear;
  logic              baud_tick;
  logic [BYTE_W-1:0] next_byte;

  // The baud counter only matters in the timed states; holding it at zero
  // elsewhere guarantees START is entered with a fresh count. Every other
  // state change happens on a tick, where the counter wraps to zero anyway.
  assign baud_clear = (state_q == ST_IDLE) || (state_q == ST_REQ) ||
                      (state_q == ST_LATCH);

  assign next_byte = byte_idx_q + 1'b1;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .reset   (reset),
    .clear_i (baud_clear),
    .tick_o  (baud_tick)
  );

  // Single FSM process; every output is registered alongside the state so
  // it reflects the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      word_q       <= '0;
      shift_q      <= '0;
      bit_idx_q    <= '0;
      byte_idx_q   <= '0;
      tx_q         <= 1'b1;
      fifo_read_q  <= 1'b0;
      busy_q       <= 1'b0;
      word_done_q  <= 1'b0;
      empty_seen_q <= 1'b0;
    end else begin
      fifo_read_q  <= 1'b0;
      word_done_q  <= 1'b0;
      empty_seen_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          tx_q <= 1'b1;
          if (enable) begin
            state_q     <= ST_REQ;
            fifo_read_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        ST_REQ: begin
          state_q <= ST_LATCH;
        end
        ST_LATCH: begin
          word_q <= fifo_data;
          if (fifo_data == EMPTY_WORD) begin
            empty_seen_q <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= ST_IDLE;
          end else begin
            byte_idx_q <= '0;
            shift_q    <= fifo_data[7:0];
            tx_q       <= 1'b0;
            state_q    <= ST_START;
          end
        end
        ST_START: begin
          if (baud_tick) begin
            bit_idx_q <= '0;
            tx_q      <= shift_q[0];
            state_q   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (baud_tick) begin
            if (bit_idx_q == LAST_BIT) begin
              tx_q    <= 1'b1;
              state_q <= ST_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
              shift_q   <= {1'b0, shift_q[7:1]};
              // Present the bit that becomes shift[0] after this shift.
              tx_q      <= shift_q[1];
            end
          end
        end
        ST_STOP: begin
          if (baud_tick) begin
            if (byte_idx_q != LAST_BYTE) begin
              byte_idx_q <= next_byte;
              shift_q    <= word_q[{next_byte, 3'b000} +: 8];
              tx_q       <= 1'b0;
              state_q    <= ST_START;
            end else begin
              word_done_q <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= ST_IDLE;
            end
          end
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign fifo_read  = fifo_read_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign word_done  = word_done_q;
  assign empty_seen = empty_seen_q;

endmodule

// File: tb/tb_uart_tx_word.sv
module tb_uart_tx_word;
  import uart_tx_word_pkg::*;

  localparam int CPB      = 4;
  localparam int W        = 32;
  localparam int NB       = W / DATA_BITS;
  localparam int WORD_CYC = NB * FRAME_BITS * CPB;   // 160
  localparam logic [W-1:0] EMPTY = 32'hFFFF_FFFF;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b0;
  logic         fifo_read;
  logic [W-1:0] fifo_data = '0;
  logic         tx, busy, word_done, empty_seen;

  uart_tx_word #(
    .WIDTH       (W),
    .CLKS_PER_BIT(CPB),
    .EMPTY_WORD  (EMPTY)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .fifo_read (fifo_read),
    .fifo_data (fifo_data),
    .tx        (tx),
    .busy      (busy),
    .word_done (word_done),
    .empty_seen(empty_seen)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  bit started = 0;
  int rd_cnt = 0;

  logic [W-1:0] words[$];      // FIFO contents
  logic [7:0]   exp_bytes[$];  // bytes expected on tx, in order
  int           exp_done[$];   // cycle each word_done is expected
  int           exp_empty[$];  // cycle each empty_seen is expected
  int           rd_cycles[$];  // cycle of every observed fifo_read

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // FIFO model: returns the head word the cycle after a read, or the
  // all-ones word when empty. Expectations are derived from the word.
  initial begin
    logic [W-1:0] w;
    int k;
    forever begin
      @(negedge clk);
      if (started && !reset && fifo_read === 1'b1) begin
        rd_cnt++;
        k = cyc;
        rd_cycles.push_back(k);
        if (words.size() != 0) w = words.pop_front();
        else w = EMPTY;
        if (w == EMPTY) begin
          exp_empty.push_back(k + 2);
        end else begin
          for (int b = 0; b < NB; b++) exp_bytes.push_back(w[8*b +: 8]);
          exp_done.push_back(k + 2 + WORD_CYC);
        end
        @(posedge clk);
        #1 fifo_data = w;
        @(posedge clk);
        #1 fifo_data = 32'h0BAD_0000 | 32'($urandom_range(0, 16'hFFFF));
      end
    end
  end

  // UART receiver: every bit must hold for exactly CPB cycles.
  initial begin
    logic [7:0] data;
    logic [7:0] e;
    logic v;
    bit aborted;
    bit framing_ok;
    forever begin
      @(negedge clk);
      if (started && !reset && tx === 1'b0) begin
        aborted = 0;
        framing_ok = 1;
        data = '0;
        v = 1'b0;
        for (int b = 0; b < FRAME_BITS; b++) begin
          for (int c = 0; c < CPB; c++) begin
            if (b != 0 || c != 0) begin
              @(negedge clk);
              if (reset) aborted = 1;
            end
            if (aborted) break;
            if (c == 0) v = tx;
            else if (tx !== v) framing_ok = 0;
          end
          if (aborted) break;
          if (b == 0 && v !== 1'b0) framing_ok = 0;
          if (b == FRAME_BITS - 1 && v !== 1'b1) framing_ok = 0;
          if (b >= 1 && b <= DATA_BITS) data[b-1] = v;
        end
        if (!aborted) begin
          check("frame_format", 64'(framing_ok), 64'd1);
          if (exp_bytes.size() == 0) begin
            check("byte_unexpected", 64'(data), 64'hxx);
          end else begin
            e = exp_bytes.pop_front();
            check("byte_value", 64'(data), 64'(e));
            $display("rx byte %02h (expected %02h) at cycle %0d", data, e, cyc);
          end
        end
      end
    end
  end

  // Pulse monitors: word_done / empty_seen timing, single-cycle reads.
  initial begin
    bit prev_rd = 0;
    forever begin
      @(negedge clk);
      if (!started || reset) begin
        prev_rd = 0;
      end else begin
        if (fifo_read === 1'b1) check("fifo_read_pulse", 64'(prev_rd), 64'd0);
        prev_rd = (fifo_read === 1'b1);

        if (word_done === 1'b1) begin
          if (exp_done.size() == 0) check("word_done_unexpected", 64'd1, 64'd0);
          else check("word_done_cycle", 64'(cyc), 64'(exp_done.pop_front()));
          check("busy_at_done", 64'(busy), 64'd0);
          $display("word_done at cycle %0d", cyc);
        end else if (exp_done.size() != 0 && exp_done[0] < cyc) begin
          check("word_done_missing", 64'd0, 64'd1);
          void'(exp_done.pop_front());
        end

        if (empty_seen === 1'b1) begin
          if (exp_empty.size() == 0) check("empty_seen_unexpected", 64'd1, 64'd0);
          else check("empty_seen_cycle", 64'(cyc), 64'(exp_empty.pop_front()));
          check("tx_idle_on_empty", 64'(tx), 64'd1);
        end else if (exp_empty.size() != 0 && exp_empty[0] < cyc) begin
          check("empty_seen_missing", 64'd0, 64'd1);
          void'(exp_empty.pop_front());
        end
      end
    end
  end

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((words.size() != 0 || exp_bytes.size() != 0 || exp_done.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", 64'(n < budget), 64'd1);
  endtask

  task automatic wait_read(output int k);
    int n = 0;
    while (rd_cycles.size() == 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (rd_cycles.size() == 0) begin
      check("read_timeout", 64'd0, 64'd1);
      k = cyc;
    end else begin
      k = rd_cycles[0];
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rel, k, rd0;
    logic [W-1:0] w;

    // Reset held 3 cycles with enable high: all outputs quiet.
    reset = 1'b1;
    enable = 1'b1;
    @(posedge clk);
    started = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_tx", 64'(tx), 64'd1);
      check("rst_fifo_read", 64'(fifo_read), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_word_done", 64'(word_done), 64'd0);
      check("rst_empty_seen", 64'(empty_seen), 64'd0);
    end
    rd_cycles.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    rel = cyc;

    // Empty FIFO: polls every 3 cycles, tx idle throughout.
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      check("tx_idle_polling", 64'(tx), 64'd1);
    end
    check("poll_count", 64'(rd_cycles.size() >= 5), 64'd1);
    if (rd_cycles.size() >= 5) begin
      check("first_read_after_reset", 64'(rd_cycles[0]), 64'(rel + 1));
      for (int i = 1; i < 5; i++)
        check("poll_period", 64'(rd_cycles[i] - rd_cycles[i-1]), 64'd3);
    end

    // Single word.
    words.push_back(32'h1234_5678);
    wait_drain(400);

    // Three words back to back.
    words.push_back(32'h0000_00A5);
    words.push_back(32'hDEAD_BEEF);
    words.push_back(32'h0000_0000);
    wait_drain(1000);

    // Randomised words.
    for (int i = 0; i < 6; i++) begin
      w = $urandom;
      if (w == EMPTY) w = 32'h0;
      words.push_back(w);
    end
    wait_drain(2000);

    // Enable dropped during byte 1: word completes, no further reads.
    enable = 1'b0;
    repeat (10) @(negedge clk);
    rd_cycles.delete();
    words.push_back(32'hCAFE_F00D);
    enable = 1'b1;
    wait_read(k);
    while (cyc < k + 2 + 12 * CPB) @(negedge clk);
    enable = 1'b0;
    rd0 = rd_cnt;
    wait_drain(400);
    repeat (20) @(negedge clk);
    check("no_read_after_disable", 64'(rd_cnt), 64'(rd0));
    check("idle_after_disable", 64'(busy), 64'd0);

    // Reset during bit 3 of byte 2, then a fresh word from byte 0.
    rd_cycles.delete();
    words.push_back(32'h5A3C_96E1);
    enable = 1'b1;
    wait_read(k);
    while (cyc < k + 2 + 24 * CPB) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    exp_bytes.delete();
    exp_done.delete();
    @(posedge clk);
    @(negedge clk);
    check("midrst_tx", 64'(tx), 64'd1);
    check("midrst_busy", 64'(busy), 64'd0);
    words.push_back(32'h8421_C3F0);
    rd_cycles.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    rel = cyc;
    wait_read(k);
    check("read_after_midrst", 64'(k), 64'(rel + 1));
    wait_drain(400);

    enable = 1'b0;
    repeat (20) @(negedge clk);
    check("queues_empty",
          64'(words.size() + exp_bytes.size() + exp_done.size() + exp_empty.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
